// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: turns a CPU MFA/READ_WRITE/WORD_BYTE request
// into one or four byte cycles on a byte-wide synchronous RAM, then MFC.
//
// Ports:
//   Clk, Reset      rising-edge clock, async active-low reset
//   MFA             level request; READ_WRITE (1=rd), WORD_BYTE (1=word),
//                   MEMADD, WrData sampled when a request is accepted
//   RdData          load data (word, or zero-extended byte)
//   MFC, Busy       completion (registered), busy accept..IDLE
//   RamAddr         RAM byte address
//   RamWrData       RAM write byte
//   RamWE, RamRE    one-cycle RAM strobes, high only in ACCESS
//   RamRdData       RAM read byte, valid the cycle after RamRE
module mem_bus_ctrl #(
   parameter int WAIT_STATES = 0,
   parameter int ADDR_W      = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              MFA,
   input  logic              READ_WRITE,
   input  logic              WORD_BYTE,
   input  logic [ADDR_W-1:0] MEMADD,
   input  logic [31:0]       WrData,
   output logic [31:0]       RdData,
   output logic              MFC,
   output logic              Busy,
   output logic [ADDR_W-1:0] RamAddr,
   output logic [7:0]        RamWrData,
   output logic              RamWE,
   output logic              RamRE,
   input  logic [7:0]        RamRdData
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      HOLD,
      DONE
   } state_e;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_e            state_q, state_d;
   logic              rw_q, rw_d;
   logic              wb_q, wb_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [3:0][7:0]   wdat_q, wdat_d;
   logic [3:0][7:0]   asm_q, asm_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic [31:0]       rd_d;
   logic              mfc_d;
   logic              busy_d;
   logic [ADDR_W-1:0] addr_d;
   logic [7:0]        wbyte_d;
   logic              we_d;
   logic              re_d;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         rw_q      <= 1'b0;
         wb_q      <= 1'b0;
         base_q    <= '0;
         wdat_q    <= '0;
         asm_q     <= '0;
         idx_q     <= '0;
         wcnt_q    <= '0;
         RdData    <= '0;
         MFC       <= 1'b0;
         Busy      <= 1'b0;
         RamAddr   <= '0;
         RamWrData <= '0;
         RamWE     <= 1'b0;
         RamRE     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rw_q      <= rw_d;
         wb_q      <= wb_d;
         base_q    <= base_d;
         wdat_q    <= wdat_d;
         asm_q     <= asm_d;
         idx_q     <= idx_d;
         wcnt_q    <= wcnt_d;
         RdData    <= rd_d;
         MFC       <= mfc_d;
         Busy      <= busy_d;
         RamAddr   <= addr_d;
         RamWrData <= wbyte_d;
         RamWE     <= we_d;
         RamRE     <= re_d;
      end
   end

   // Strobes and RAM address are registered: they are set on the edge that
   // enters ACCESS, so they are high for exactly the ACCESS cycle.
   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      wb_d    = wb_q;
      base_d  = base_q;
      wdat_d  = wdat_q;
      asm_d   = asm_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      rd_d    = RdData;
      mfc_d   = MFC;
      busy_d  = Busy;
      addr_d  = RamAddr;
      wbyte_d = RamWrData;
      we_d    = 1'b0;
      re_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (MFA) begin
               rw_d    = READ_WRITE;
               wb_d    = WORD_BYTE;
               base_d  = WORD_BYTE ? {MEMADD[ADDR_W-1:2], 2'b00}
                                   : MEMADD;
               wdat_d  = WrData;
               idx_d   = '0;
               wcnt_d  = '0;
               busy_d  = 1'b1;
               addr_d  = base_d;
               re_d    = READ_WRITE;
               we_d    = !READ_WRITE;
               wbyte_d = WrData[7:0];
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            wcnt_d  = '0;
            state_d = HOLD;
         end
         HOLD: begin
            if (wcnt_q != WS) begin
               wcnt_d = 4'(wcnt_q + 4'd1);
            end else begin
               wcnt_d = '0;
               if (rw_q)
                  asm_d[idx_q] = RamRdData;
               if (!wb_q || idx_q == 2'd3) begin
                  // Whole word lands on RdData in one edge,
                  // including the byte sampled right now.
                  mfc_d   = 1'b1;
                  state_d = DONE;
                  if (rw_q)
                     rd_d = wb_q ? asm_d : {24'b0, RamRdData};
               end else begin
                  idx_d   = 2'(idx_q + 2'd1);
                  addr_d  = base_q + ADDR_W'(idx_d);
                  re_d    = rw_q;
                  we_d    = !rw_q;
                  wbyte_d = wdat_q[idx_d];
                  state_d = ACCESS;
               end
            end
         end
         DONE: begin
            if (!MFA) begin
               mfc_d   = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side bus controller between the CPU control unit and a byte-wide synchronous RAM.
- Accepts the CPU's MFA / READ_WRITE / WORD_BYTE / MEMADD request and sequences one (byte) or four (word) RAM byte cycles.
- Assembles or splits 32-bit data, then answers with MFC.
- Replaces the bidirectional data bus with split read/write buses.

Parameters:
- WAIT_STATES, 0, extra hold cycles inserted after every RAM byte strobe (0..15).
- ADDR_W, 8, address width on both the CPU and RAM sides.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- MFA  in  1  memory function request from the CPU, level
- READ_WRITE  in  1  1 = read, 0 = write; sampled with MFA
- WORD_BYTE  in  1  1 = 32-bit word, 0 = byte; sampled with MFA
- MEMADD  in  ADDR_W  byte address from the CPU
- WrData  in  32  CPU store data; byte stores use bits 7:0
- RdData  out  32  load data returned to the CPU
- MFC  out  1  memory function complete, registered
- Busy  out  1  high from request accept until return to IDLE
- RamAddr  out  ADDR_W  RAM byte address
- RamWrData  out  8  RAM write byte
- RamWE  out  1  RAM write strobe, one cycle
- RamRE  out  1  RAM read strobe, one cycle
- RamRdData  in  8  RAM read byte, valid the cycle after RamRE

Behaviour:
- Reset (Reset=0) takes effect immediately, mid-transfer included:
  - state IDLE;
  - RdData, RamAddr, RamWrData = 0;
  - MFC, Busy, RamWE, RamRE = 0;
  - internal byte index and wait counter = 0.
- States: IDLE, ACCESS, HOLD, DONE.
- IDLE:
  - MFA=1 at a clock edge latches READ_WRITE, WORD_BYTE, MEMADD and WrData, sets Busy, then goes to ACCESS.
  - Later changes on those inputs are ignored until the next accept.
- Base address:
  - word access: {MEMADD[ADDR_W-1:2], 2'b00}; low two bits ignored, so the access never wraps;
  - byte access: MEMADD as given.
- Byte count: word = 4 (index 0..3), byte = 1 (index 0).
- Byte order is little-endian: byte index i occupies data bits 8i+7:8i.
- ACCESS (exactly 1 cycle):
  - RamAddr = base + index;
  - read: RamRE=1;
  - write: RamWE=1 and RamWrData = latched WrData byte[index];
  - next state HOLD.
- HOLD (1 + WAIT_STATES cycles, strobes low):
  - on a read, RamRdData is sampled into assembly byte[index] at the final HOLD edge;
  - if more bytes remain, index increments and the FSM returns to ACCESS; otherwise it goes to DONE.
- Word read completion:
  - on entering DONE, RdData takes all four assembled bytes at once;
  - no partial words are ever visible on RdData.
- Byte read completion: RdData = {24'b0, byte} (zero-extended).
- Writes leave RdData unchanged.
- DONE:
  - MFC=1 and held while MFA=1;
  - when MFA=0, next edge clears MFC and Busy and returns to IDLE.
- MFA dropped mid-transfer: the transfer still completes; DONE then lasts exactly one cycle (a one-cycle MFC pulse).
- No back-to-back accept: MFA must be seen low in DONE first, so a held MFA never retriggers.
- Latency, counted from the accepting edge to MFC high: 1 + N*(2+WAIT_STATES) edges, where N is the byte count.
  - With WAIT_STATES=0: byte = 3 edges, word = 9 edges.
- RamWE and RamRE are never high together and never high outside ACCESS.
- Address arithmetic is ADDR_W bits, unsigned.

Test Plan:
- Word write then read, WAIT_STATES=0:
  - write MEMADD=0x10, WrData=0xDEADBEEF → RAM[0x10..0x13] = EF,BE,AD,DE; MFC high 9 edges after accept.
  - read MEMADD=0x10 → RdData=0xDEADBEEF.
- Byte read, RAM[0x23]=0x9C, MEMADD=0x23, WORD_BYTE=0 → one RamRE at address 0x23, RdData=0x0000009C, MFC after 3 edges.
- Misaligned word read at MEMADD=0xFE → RAM accessed at 0xFC,0xFD,0xFE,0xFF, RamAddr never wraps to 0x00.
- Wait states, WAIT_STATES=2, word write → strobes 4 cycles apart, MFC after 1+4*4=17 edges.
- MFA deasserted 2 cycles after accept on a word write → all 4 RamWE pulses still occur, MFC high for exactly 1 cycle, Busy low the next cycle.
- Reset=0 asserted during the third HOLD of a word read → RamRE, MFC, Busy and RdData go to 0 without a clock edge; the next request after release runs from index 0.
